// File: rtl/uart_text_filter_pkg.sv
// Shared definitions for the UART text filter.
//   - transform mode codes carried on the 2-bit mode input
//   - ASCII constants used by the transform and the CR/LF expansion
//   - TX FSM state encoding
//   - xform_byte(): the per-byte transform applied when a byte is written
package uart_text_filter_pkg;

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_ROT   = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_LOWER = 2'b11;

    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_A  = 8'h41;
    localparam logic [7:0] CHR_Z  = 8'h5A;
    localparam logic [7:0] CHR_a  = 8'h61;
    localparam logic [7:0] CHR_z  = 8'h7A;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_e;

    // Rotate a letter within its own 26-letter alphabet starting at base.
    // n is already reduced to 0..25, so one conditional subtract is enough.
    function automatic logic [7:0] rot_letter(input logic [7:0] c,
                                              input logic [7:0] base,
                                              input logic [7:0] n);
        logic [7:0] sum;
        sum = (c - base) + n;
        if (sum >= 8'd26) begin
            sum = sum - 8'd26;
        end
        return base + sum;
    endfunction

    function automatic logic [7:0] xform_byte(input logic [7:0] c,
                                              input logic [1:0] mode,
                                              input logic [7:0] rot_n);
        logic [7:0] res;
        logic       is_upper;
        logic       is_lower;
        is_upper = (c >= CHR_A) && (c <= CHR_Z);
        is_lower = (c >= CHR_a) && (c <= CHR_z);
        res      = c;
        case (mode)
            MODE_ROT: begin
                if (is_upper) begin
                    res = rot_letter(c, CHR_A, rot_n);
                end else if (is_lower) begin
                    res = rot_letter(c, CHR_a, rot_n);
                end
            end
            MODE_UPPER: begin
                if (is_lower) begin
                    res = c - 8'h20;
                end
            end
            MODE_LOWER: begin
                if (is_upper) begin
                    res = c + 8'h20;
                end
            end
            default: res = c;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_text_filter_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with registered storage.
//   clk, rstn   : clock, asynchronous active-low reset (pointers only)
//   push, din   : write request and data; ignored when full
//   pop         : read request; ignored when empty; dout advances next cycle
//   dout        : head entry, valid whenever empty is low
//   full, empty : occupancy flags
//   level       : current occupancy, 0..DEPTH
// Pointers carry one extra MSB so that full (MSBs differ, index equal) and
// empty (pointers equal) are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level   = wr_q - rd_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) begin
            wr_d = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_text_filter.sv
// uart_text_filter: sits between a uart_rx (rcv/data) and a uart_tx
// (start/data/ready). Received bytes are transformed at write time according
// to mode, buffered in a FIFO and sent out one per tx_ready window, with an
// optional LF inserted after every transmitted CR.
//   clk, rstn : clock, asynchronous active-low reset
//   mode      : 00 pass, 01 ROT-N, 10 upper-case, 11 lower-case
//   rx_rcv    : one-cycle strobe, rx_data valid
//   rx_data   : received byte
//   tx_ready  : transmitter idle
//   tx_start  : one-cycle strobe, load tx_data into the transmitter
//   tx_data   : byte to transmit, held until the next tx_start
//   level     : FIFO occupancy
//   loss_cnt  : saturating count of bytes dropped because the FIFO was full
//   overflow  : sticky drop flag, cleared only by reset
// Handshake: a byte is handed to the transmitter in the cycle tx_start is
// high; tx_start is only raised while tx_ready is high and the FSM is IDLE,
// and the following HOLD cycle ignores tx_ready because the transmitter
// drops it one cycle late.
module uart_text_filter
    import uart_text_filter_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ROT_N   = 13,
    parameter int CRLF_EN = 1,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [1:0]             mode,
    input  logic                   rx_rcv,
    input  logic [7:0]             rx_data,
    input  logic                   tx_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       loss_cnt,
    output logic                   overflow
);

    localparam logic [7:0] ROT_AMT = 8'(ROT_N % 26);

    tx_state_e        state_q, state_d;
    logic             lf_pending_q, lf_pending_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             ovf_q, ovf_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [7:0]       wr_byte;
    logic             push;
    logic             drop;
    logic             pop;
    logic             launch;
    logic [7:0]       launch_byte;

    // A byte arriving while full is lost even if a pop frees a slot this cycle.
    assign wr_byte = xform_byte(rx_data, mode, ROT_AMT);
    assign push    = rx_rcv && !fifo_full;
    assign drop    = rx_rcv && fifo_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (wr_byte),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // TX FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= TX_IDLE;
            lf_pending_q <= 1'b0;
            tx_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            lf_pending_q <= lf_pending_d;
            tx_data_q    <= tx_data_d;
        end
    end

    // TX FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE: begin
                if (tx_ready && (lf_pending_q || !fifo_empty)) begin
                    state_d = TX_HOLD;
                end
            end
            TX_HOLD: state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    // TX FSM: outputs. The launch is combinational so a byte written in one
    // cycle can start in the next; tx_data is then held in tx_data_q.
    always_comb begin
        launch       = 1'b0;
        pop          = 1'b0;
        launch_byte  = tx_data_q;
        lf_pending_d = lf_pending_q;
        if (state_q == TX_IDLE && tx_ready) begin
            if (lf_pending_q) begin
                // The pending LF always goes before the next FIFO byte.
                launch       = 1'b1;
                launch_byte  = CHR_LF;
                lf_pending_d = 1'b0;
            end else if (!fifo_empty) begin
                launch      = 1'b1;
                pop         = 1'b1;
                launch_byte = fifo_dout;
                if (fifo_dout == CHR_CR && CRLF_EN != 0) begin
                    lf_pending_d = 1'b1;
                end
            end
        end
        tx_data_d = launch ? launch_byte : tx_data_q;
        tx_start  = launch;
        tx_data   = tx_data_d;
    end

    // Loss accounting
    always_comb begin
        loss_d = loss_q;
        ovf_d  = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (loss_q != {CNT_W{1'b1}}) begin
                loss_d = loss_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            loss_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            loss_q <= loss_d;
            ovf_q  <= ovf_d;
        end
    end

    assign loss_cnt = loss_q;
    assign overflow = ovf_q;

endmodule
